// File: rtl/control_part5_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// control_part5_if : load/result handshake and bank-control bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface control_part5_if #(
  parameter int N     = 8,
  parameter int LANES = 2
);
  localparam int K    = N / LANES;
  localparam int AW_W = $clog2(N * K);
  localparam int AW_X = (K > 1) ? $clog2(K) : 1;
  localparam int RW   = $clog2(N);

  logic             input_valid;
  logic             input_ready;
  logic             new_matrix;
  logic             output_ready;
  logic             output_valid;
  logic             output_last;
  logic [RW-1:0]    out_row;
  logic [AW_W-1:0]  addr_w;
  logic [LANES-1:0] wr_en_w;
  logic [AW_X-1:0]  addr_x;
  logic [LANES-1:0] wr_en_x;
  logic             en_reg_mult;
  logic             en_acc;
  logic             clear_acc;

  modport master (
    input  input_valid, new_matrix, output_ready,
    output input_ready, output_valid, output_last, out_row,
           addr_w, wr_en_w, addr_x, wr_en_x,
           en_reg_mult, en_acc, clear_acc
  );

  modport slave (
    output input_valid, new_matrix, output_ready,
    input  input_ready, output_valid, output_last, out_row,
           addr_w, wr_en_w, addr_x, wr_en_x,
           en_reg_mult, en_acc, clear_acc
  );
endinterface
`default_nettype wire

// File: rtl/control_part5.sv
`default_nettype none
// ----------------------------------------------------------------------------
// control_part5 : load / issue / drain / send sequencer for a banked MAC array
// Rev 1.0
// ----------------------------------------------------------------------------
module control_part5 #(
  parameter int N     = 8,
  parameter int LANES = 2,
  parameter int PIPE  = 5
) (
  input  logic            clk,
  input  logic            rst,
  control_part5_if.master bus_io
);
  localparam int K    = N / LANES;
  localparam int AW_W = $clog2(N * K);
  localparam int AW_X = (K > 1) ? $clog2(K) : 1;
  localparam int RW   = $clog2(N);
  localparam int BW   = $clog2(N * N);
  localparam int DW   = $clog2(PIPE + 1);
  localparam int PW   = PIPE - 1;

  localparam logic [BW-1:0]   W_LAST = BW'(N * N - 1);
  localparam logic [BW-1:0]   X_LAST = BW'(N - 1);
  localparam logic [AW_X-1:0] K_LAST = AW_X'(K - 1);
  localparam logic [RW-1:0]   R_LAST = RW'(N - 1);
  localparam logic [DW-1:0]   D_LAST = DW'(PIPE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_X = 3'd2,
    S_ISSUE  = 3'd3,
    S_DRAIN  = 3'd4,
    S_SEND   = 3'd5
  } state_t;

  state_t           state_q;
  logic [BW-1:0]    beat_q;
  logic [AW_X-1:0]  k_q;
  logic [RW-1:0]    r_q;
  logic [DW-1:0]    dcnt_q;
  logic [PW-1:0]    pipe_q;

  logic             running;
  logic             ready;
  logic             accept;
  logic             load_w;
  logic             load_x;
  logic             issue;
  logic             send;
  logic             handshake;
  logic [BW-1:0]    beat_addr;
  logic [LANES-1:0] bank;

  // The first beat in IDLE is already a real write, so its target bank
  // follows new_matrix on that same cycle.
  always_comb begin
    running   = ~rst;
    ready     = running && (state_q == S_IDLE || state_q == S_LOAD_W ||
                            state_q == S_LOAD_X);
    accept    = ready && bus_io.input_valid;
    load_w    = accept && (state_q == S_LOAD_W ||
                           (state_q == S_IDLE && bus_io.new_matrix));
    load_x    = accept && (state_q == S_LOAD_X ||
                           (state_q == S_IDLE && !bus_io.new_matrix));
    issue     = (state_q == S_ISSUE);
    send      = (state_q == S_SEND);
    handshake = send && bus_io.output_ready;
    beat_addr = beat_q / BW'(LANES);
    bank      = LANES'(1) << (beat_q % BW'(LANES));
  end

  assign bus_io.input_ready  = ready;
  assign bus_io.wr_en_w      = load_w ? bank : '0;
  assign bus_io.wr_en_x      = load_x ? bank : '0;
  assign bus_io.addr_w       = issue ? (AW_W'(r_q) * AW_W'(K) + AW_W'(k_q))
                             : (state_q == S_IDLE || state_q == S_LOAD_W) ? AW_W'(beat_addr)
                             : '0;
  assign bus_io.addr_x       = issue ? k_q
                             : (state_q == S_IDLE || state_q == S_LOAD_X) ? AW_X'(beat_addr)
                             : '0;
  assign bus_io.en_reg_mult  = issue;
  assign bus_io.en_acc       = pipe_q[PW-1];
  assign bus_io.clear_acc    = running && (state_q == S_IDLE || handshake);
  assign bus_io.output_valid = send;
  assign bus_io.output_last  = send && (r_q == R_LAST);
  assign bus_io.out_row      = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      k_q     <= '0;
      r_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            beat_q  <= BW'(1);
            state_q <= bus_io.new_matrix ? S_LOAD_W : S_LOAD_X;
          end
        end
        S_LOAD_W: begin
          if (accept) begin
            if (beat_q == W_LAST) begin
              beat_q  <= '0;
              state_q <= S_LOAD_X;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        S_LOAD_X: begin
          if (accept) begin
            if (beat_q == X_LAST) begin
              beat_q  <= '0;
              k_q     <= '0;
              state_q <= S_ISSUE;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (k_q == K_LAST) begin
            k_q     <= '0;
            dcnt_q  <= '0;
            state_q <= S_DRAIN;
          end else begin
            k_q <= k_q + AW_X'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == D_LAST) begin
            dcnt_q  <= '0;
            state_q <= S_SEND;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        S_SEND: begin
          if (bus_io.output_ready) begin
            if (r_q == R_LAST) begin
              r_q     <= '0;
              state_q <= S_IDLE;
            end else begin
              r_q     <= r_q + RW'(1);
              k_q     <= '0;
              state_q <= S_ISSUE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Accumulate strobe trails the multiplier-register strobe by PIPE-1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | PW'(issue);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_part5.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_control_part5 : randomized directed bench for control_part5
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_part5;
  localparam int N     = 8;
  localparam int LANES = 2;
  localparam int PIPE  = 5;
  localparam int K     = N / LANES;
  localparam int N2    = 4;
  localparam int L2    = 1;
  localparam int P2    = 2;
  localparam int K2    = N2 / L2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  control_part5_if #(.N(N),  .LANES(LANES)) ifa ();
  control_part5_if #(.N(N2), .LANES(L2))    ifb ();

  control_part5 #(.N(N), .LANES(LANES), .PIPE(PIPE)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ifa.master)
  );

  control_part5 #(.N(N2), .LANES(L2), .PIPE(P2)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus_io (ifb.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {ifa.input_ready, ifa.output_valid, ifa.output_last, ifa.out_row,
                ifa.addr_w, ifa.wr_en_w, ifa.addr_x, ifa.wr_en_x,
                ifa.en_reg_mult, ifa.en_acc, ifa.clear_acc}, 0);
  endtask

  // Beat i of a load goes to bank i%LANES at address i/LANES.
  task automatic load(input bit with_w, input int pct);
    int total;
    int i;
    int guard;
    int xi;
    int w_pulses;
    int x_pulses;
    bit v;
    logic [31:0] ew;
    logic [31:0] ex;
    total    = with_w ? N * N + N : N;
    i        = 0;
    guard    = 0;
    w_pulses = 0;
    x_pulses = 0;
    while (i < total && guard < 4000) begin
      @(negedge clk);
      v = ($urandom_range(0, 99) < pct);
      ifa.input_valid  = v;
      ifa.new_matrix   = (i == 0) ? with_w : 1'($urandom);
      ifa.output_ready = 1'($urandom);
      #1;
      check("ld_ready", ifa.input_ready, 1);
      ew = 0;
      ex = 0;
      if (with_w && i < N * N) begin
        if (v) begin
          ew = 1 << (i % LANES);
          check("ld_addr_w", ifa.addr_w, i / LANES);
        end
      end else begin
        xi = with_w ? i - N * N : i;
        if (v) begin
          ex = 1 << (xi % LANES);
          check("ld_addr_x", ifa.addr_x, xi / LANES);
        end
      end
      check("ld_wr_en_w", ifa.wr_en_w, ew);
      check("ld_wr_en_x", ifa.wr_en_x, ex);
      if (ifa.wr_en_w != 0) w_pulses++;
      if (ifa.wr_en_x != 0) x_pulses++;
      if (v) i++;
      guard++;
    end
    check("ld_done", i, total);
    check("ld_w_total", w_pulses, with_w ? N * N : 0);
    check("ld_x_total", x_pulses, N);
  endtask

  // Row r: K issue cycles, PIPE drain cycles, then the result is offered.
  task automatic run_rows(input int stall_row, input int stall_len,
                          input int abort_row, input bit rand_stall);
    int stall;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < K + PIPE; c++) begin
        @(negedge clk);
        ifa.input_valid  = 1'($urandom);
        ifa.new_matrix   = 1'($urandom);
        ifa.output_ready = 1'($urandom);
        if (r == abort_row && c == 1) begin
          rst = 1'b1;
          #1;
          check_zero("rst_mid_issue");
          repeat (2) @(negedge clk);
          ifa.input_valid = 1'b1;
          #1;
          check_zero("rst_held");
          rst = 1'b0;
          ifa.input_valid = 1'b0;
          #1;
          check("rst_release_ready", ifa.input_ready, 1);
          return;
        end
        #1;
        check("iss_en_mult", ifa.en_reg_mult, c < K);
        if (c < K) begin
          check("iss_addr_w", ifa.addr_w, r * K + c);
          check("iss_addr_x", ifa.addr_x, c);
        end
        check("iss_en_acc", ifa.en_acc, (c >= PIPE - 1) && (c < PIPE - 1 + K));
        check("busy_valid", ifa.output_valid, 0);
        check("busy_ready", ifa.input_ready, 0);
        check("busy_clear", ifa.clear_acc, 0);
        check("busy_wr_en", {ifa.wr_en_w, ifa.wr_en_x}, 0);
      end
      stall = (r == stall_row) ? stall_len : (rand_stall ? $urandom_range(0, 2) : 0);
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        ifa.output_ready = (s == stall);
        ifa.input_valid  = 1'($urandom);
        #1;
        check("snd_valid", ifa.output_valid, 1);
        check("snd_row", ifa.out_row, r);
        check("snd_last", ifa.output_last, r == N - 1);
        check("snd_mult_acc", {ifa.en_reg_mult, ifa.en_acc}, 0);
        check("snd_clear", ifa.clear_acc, s == stall);
        check("snd_ready", ifa.input_ready, 0);
      end
    end
    @(negedge clk);
    ifa.input_valid  = 1'b0;
    ifa.output_ready = 1'b0;
    #1;
    check("idle_ready", ifa.input_ready, 1);
    check("idle_clear", ifa.clear_acc, 1);
    check("idle_valid", ifa.output_valid, 0);
    check("idle_row", ifa.out_row, 0);
  endtask

  // Single-lane, short-pipeline instance: bank enable is a constant 1.
  task automatic run_b();
    for (int i = 0; i < N2 * N2 + N2; i++) begin
      @(negedge clk);
      ifb.input_valid = 1'b1;
      ifb.new_matrix  = (i == 0);
      #1;
      if (i < N2 * N2) begin
        check("b_wr_en_w", ifb.wr_en_w, 1);
        check("b_wr_en_x_off", ifb.wr_en_x, 0);
        check("b_addr_w", ifb.addr_w, i);
      end else begin
        check("b_wr_en_x", ifb.wr_en_x, 1);
        check("b_addr_x", ifb.addr_x, i - N2 * N2);
      end
    end
    for (int t = 0; t <= K2 + P2; t++) begin
      @(negedge clk);
      ifb.input_valid  = 1'b0;
      ifb.output_ready = 1'b1;
      #1;
      check("b_valid_timing", ifb.output_valid, t == K2 + P2);
    end
  endtask

  initial begin
    #1_000_000;
    mismatched++;
    $display("FAIL watchdog: observed still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    ifa.input_valid  = 1'b0;
    ifa.new_matrix   = 1'b0;
    ifa.output_ready = 1'b0;
    ifb.input_valid  = 1'b0;
    ifb.new_matrix   = 1'b0;
    ifb.output_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ifa.input_valid = 1'b1;
    ifa.new_matrix  = 1'b1;
    #1;
    check_zero("reset_outputs");
    check("reset_b_ready", ifb.input_ready, 0);

    @(negedge clk);
    ifa.input_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("release_ready", ifa.input_ready, 1);
    check("release_clear", ifa.clear_acc, 1);

    load(1'b1, 100);
    run_rows(-1, 0, -1, 1'b0);
    load(1'b0, 100);
    run_rows(3, 10, -1, 1'b0);
    load(1'b1, 60);
    run_rows(-1, 0, -1, 1'b1);
    load(1'b0, 70);
    run_rows(-1, 0, 2, 1'b1);
    load(1'b1, 50);
    run_rows(-1, 0, -1, 1'b1);
    run_b();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
